lcu_datapath: RTL and testbench
===============================

Name: lcu_datapath

Overview:
- Arithmetic datapath driven by the lcu control FSM; it executes the select, mode and enable commands the controller issues.
- Holds an accumulator and three captured operand registers, and performs add or subtract steps.
- Returns the carry into the MSB (c6) and the carry out of the MSB (c7) to the controller for overflow detection.
- Sits beside lcu: lcu outputs s0/s1/s2/m/e feed this block, and this block's c6/c7 feed lcu.

Parameters:
- WIDTH, 8, data width of operands and accumulator; c6/c7 are the carries into and out of bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s0  input  1  select bit 0 from lcu.
- s1  input  1  select bit 1 from lcu.
- s2  input  1  select bit 2 from lcu.
- m  input  1  0 = add, 1 = subtract.
- e  input  1  step enable; no register changes while e=0.
- in_a  input  WIDTH  initial accumulator value, captured on load.
- in_b  input  WIDTH  operand B, captured on load.
- in_c  input  WIDTH  operand C, captured on load.
- in_d  input  WIDTH  operand D, captured on load.
- c6  output  1  combinational carry into the MSB of the current adder result.
- c7  output  1  combinational carry out of the MSB of the current adder result.
- acc  output  WIDTH  accumulator register.
- ovf_flag  output  1  sticky signed-overflow flag, registered.
- step_cnt  output  2  count of arithmetic steps committed since the last load.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - acc, op_b, op_c, op_d = 0; ovf_flag = 0; step_cnt = 0.
  - Reset has priority over e and over any select code.
  - A reset mid-sequence discards everything; the next command starts from clean state.
- Select code sel = {s2,s1,s0}. Operand mux opnd:
  - 001 -> op_b
  - 011 -> op_c
  - 100 -> op_d
  - 101 -> op_d
  - 000, 010, 110, 111 -> 0
  - Any sel containing X/Z is treated as 000.
- Adder (combinational, every cycle, independent of e):
  - sum = acc + (m ? ~opnd : opnd) + m, computed WIDTH+1 wide.
  - c7 = sum[WIDTH].
  - c6 = carry into bit WIDTH-1 = acc[W-1] ^ opnd'[W-1] ^ sum[W-1], where opnd' is the possibly inverted operand.
  - Signed overflow sovf = c6 ^ c7.
  - c6/c7 are valid in the same cycle the command is presented; lcu samples them before the edge.
- Load (e=1, sel=000), one cycle:
  - acc <= in_a; op_b <= in_b; op_c <= in_c; op_d <= in_d.
  - ovf_flag <= 0; step_cnt <= 0.
  - m is ignored on load.
- Arithmetic step (e=1, sel in {001,011,100,101}):
  - acc <= sum[WIDTH-1:0].
  - ovf_flag <= ovf_flag | sovf.
  - step_cnt <= step_cnt + 1, saturating at 3.
  - Operand registers hold.
- e=1 with sel in {010,110,111}: no state change; c6/c7 still reflect acc + 0.
- e=0: all registers hold regardless of sel or m; c6/c7 still update combinationally.
- Latency: one clock from command to updated acc; acc and ovf_flag are visible the cycle after the edge.
- Wrap-around: without the optional feature, the result wraps modulo 2^WIDTH.
- Subtract of 0: ~0 + 1 gives c7=1 and acc unchanged.

Optional Feature:
- Macro LCU_DATAPATH_SATURATE_EN.
- When defined, an arithmetic step with sovf=1 loads the signed limit instead of the wrapped sum:
  - 0x7F (max positive) if acc[W-1]=0.
  - 0x80 (min negative) if acc[W-1]=1.
- ovf_flag, c6 and c7 behave identically with or without the macro; only the value written to acc differs.
- When undefined, the wrapped sum is written.

Decomposition:
- Package lcu_pkg holds:
  - Select encodings: SEL_LOAD=3'b000, SEL_B=3'b001, SEL_C=3'b011, SEL_D_ADD=3'b100, SEL_D_SUB=3'b101.
  - Mode constants: M_ADD=0, M_SUB=1.
  - Shared by lcu and lcu_datapath.
- One sub-module, lcu_addsub: purely combinational WIDTH-bit add/subtract producing sum, c6 and c7.
- Registers, operand mux and saturation logic live in lcu_datapath.

Test Plan:
- Reset with arbitrary inputs -> acc=0x00, ovf_flag=0, step_cnt=0 on the next cycle.
- Load in_a=0x10, in_b=0x05, in_c=0x03, in_d=0x02. Then sel=001/m=0 -> acc=0x15; sel=011/m=0 -> acc=0x18; sel=101/m=1 -> acc=0x16. Expect step_cnt=3, ovf_flag=0.
- Load in_a=0x7F, in_b=0x01; sel=001/m=0 -> c6=1, c7=0 before the edge; after the edge acc=0x80 (0x7F with SATURATE_EN) and ovf_flag=1.
- Continue with an overflow-free step -> ovf_flag stays 1. A new load -> ovf_flag=0.
- e=0 with sel=001 for 4 cycles -> acc, step_cnt and operand registers unchanged while c6/c7 track acc+op_b.
- Assert reset in the same cycle as e=1/sel=001 -> reset wins: acc=0, step_cnt=0.

Source files
------------

// File: rtl/lcu_pkg.sv
// Shared select/mode encodings and command decode for lcu and lcu_datapath.
package lcu_pkg;

    localparam logic [2:0] SEL_LOAD  = 3'b000;
    localparam logic [2:0] SEL_B     = 3'b001;
    localparam logic [2:0] SEL_C     = 3'b011;
    localparam logic [2:0] SEL_D_ADD = 3'b100;
    localparam logic [2:0] SEL_D_SUB = 3'b101;

    localparam logic M_ADD = 1'b0;
    localparam logic M_SUB = 1'b1;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_STEP = 2'd1,
        CMD_NOP  = 2'd2
    } cmd_e;

    // Unused codes are explicit no-ops; anything unmatched (incl. X/Z) decodes as a load.
    function automatic cmd_e decode_sel(input logic [2:0] sel);
        cmd_e cmd;
        case (sel)
            SEL_B, SEL_C, SEL_D_ADD, SEL_D_SUB: cmd = CMD_STEP;
            3'b010, 3'b110, 3'b111:             cmd = CMD_NOP;
            default:                            cmd = CMD_LOAD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcu_addsub.sv
// Combinational WIDTH-bit add/subtract returning the carries into and out of the MSB.
module lcu_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c6_o,
    output logic             c7_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;

    assign b_eff    = sub_i ? ~b_i : b_i;
    assign sum_full = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH+1)'(sub_i);

    assign sum_o = sum_full[WIDTH-1:0];
    assign c7_o  = sum_full[WIDTH];
    // Carry into the MSB recovered from the MSB's own sum bit.
    assign c6_o  = a_i[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];

endmodule

// File: rtl/lcu_datapath.sv
// Accumulator datapath commanded by lcu; optional signed saturation via LCU_DATAPATH_SATURATE_EN.
module lcu_datapath
    import lcu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             m,
    input  logic             e,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             c6,
    output logic             c7,
    output logic [WIDTH-1:0] acc,
    output logic             ovf_flag,
    output logic [1:0]       step_cnt
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(3);

    logic [WIDTH-1:0] acc_q,  acc_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] op_c_q, op_c_d;
    logic [WIDTH-1:0] op_d_q, op_d_d;
    logic             ovf_q,  ovf_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic [2:0]       sel;
    cmd_e             cmd;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] step_val;
    logic             sovf;
    logic             add_c6;
    logic             add_c7;

    assign sel = {s2, s1, s0};
    assign cmd = decode_sel(sel);

    // Operand mux; unknown or unused codes feed zero.
    always_comb begin
        opnd = '0;
        case (sel)
            SEL_B:                opnd = op_b_q;
            SEL_C:                opnd = op_c_q;
            SEL_D_ADD, SEL_D_SUB: opnd = op_d_q;
            default:              opnd = '0;
        endcase
    end

    lcu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i   (acc_q),
        .b_i   (opnd),
        .sub_i (m),
        .sum_o (sum),
        .c6_o  (add_c6),
        .c7_o  (add_c7)
    );

    assign sovf = add_c6 ^ add_c7;

`ifdef LCU_DATAPATH_SATURATE_EN
    always_comb begin
        step_val = sum;
        if (sovf) begin
            step_val = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign step_val = sum;
`endif

    always_comb begin
        acc_d  = acc_q;
        op_b_d = op_b_q;
        op_c_d = op_c_q;
        op_d_d = op_d_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        if (e) begin
            case (cmd)
                CMD_LOAD: begin
                    acc_d  = in_a;
                    op_b_d = in_b;
                    op_c_d = in_c;
                    op_d_d = in_d;
                    ovf_d  = 1'b0;
                    cnt_d  = '0;
                end
                CMD_STEP: begin
                    acc_d = step_val;
                    ovf_d = ovf_q | sovf;
                    cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            op_b_q <= '0;
            op_c_q <= '0;
            op_d_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            op_b_q <= op_b_d;
            op_c_q <= op_c_d;
            op_d_q <= op_d_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign c6       = add_c6;
    assign c7       = add_c7;
    assign acc      = acc_q;
    assign ovf_flag = ovf_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_lcu_datapath.sv
// Directed self-checking bench for lcu_datapath; honours LCU_DATAPATH_SATURATE_EN.
module tb_lcu_datapath;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             s0, s1, s2, m, e;
    logic [WIDTH-1:0] in_a, in_b, in_c, in_d;
    logic             c6, c7;
    logic [WIDTH-1:0] acc;
    logic             ovf_flag;
    logic [1:0]       step_cnt;

    int n_cmp;
    int n_err;

    lcu_datapath #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .m        (m),
        .e        (e),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_c     (in_c),
        .in_d     (in_d),
        .c6       (c6),
        .c7       (c7),
        .acc      (acc),
        .ovf_flag (ovf_flag),
        .step_cnt (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a command mid-cycle, leaving time for the combinational carries to settle.
    task automatic drive(input logic [2:0] sel, input logic mm, input logic ee);
        @(negedge clk);
        {s2, s1, s0} = sel;
        m = mm;
        e = ee;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        in_a = a; in_b = b; in_c = c; in_d = d;
        drive(3'b000, 1'b1, 1'b1);
        tick();
    endtask

    task automatic check_regs(input string tag, input logic [7:0] a,
                              input logic o, input logic [1:0] n);
        check({tag, ".acc"}, 32'(acc), 32'(a));
        check({tag, ".ovf"}, 32'(ovf_flag), 32'(o));
        check({tag, ".cnt"}, 32'(step_cnt), 32'(n));
    endtask

    logic [7:0] ovf_res;

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef LCU_DATAPATH_SATURATE_EN
        ovf_res = 8'h7F;
`else
        ovf_res = 8'h80;
`endif
        reset = 1'b1;
        {s2, s1, s0} = 3'b001;
        m = 1'b0; e = 1'b1;
        in_a = 8'hA5; in_b = 8'h5A; in_c = 8'h3C; in_d = 8'hC3;
        tick();
        tick();
        check_regs("reset", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic add/add/sub sequence.
        load(8'h10, 8'h05, 8'h03, 8'h02);
        check_regs("load1", 8'h10, 1'b0, 2'd0);
        drive(3'b001, 1'b0, 1'b1); tick();
        check("add_b.acc", 32'(acc), 32'h15);
        drive(3'b011, 1'b0, 1'b1); tick();
        check("add_c.acc", 32'(acc), 32'h18);
        drive(3'b101, 1'b1, 1'b1);
        check("sub_d.c7", 32'(c7), 32'h1);
        check("sub_d.c6", 32'(c6), 32'h1);
        tick();
        check_regs("sub_d", 8'h16, 1'b0, 2'd3);
        drive(3'b001, 1'b0, 1'b1); tick();
        check_regs("cnt_sat", 8'h1B, 1'b0, 2'd3);

        // Positive overflow.
        load(8'h7F, 8'h01, 8'h00, 8'h00);
        drive(3'b001, 1'b0, 1'b1);
        check("ovf.c6", 32'(c6), 32'h1);
        check("ovf.c7", 32'(c7), 32'h0);
        tick();
        check_regs("ovf", ovf_res, 1'b1, 2'd1);
        drive(3'b011, 1'b0, 1'b1); tick();
        check_regs("sticky", ovf_res, 1'b1, 2'd2);
        drive(3'b011, 1'b1, 1'b1);
        check("sub0.c7", 32'(c7), 32'h1);
        check("sub0.c6", 32'(c6), 32'h1);
        tick();
        check_regs("sub0", ovf_res, 1'b1, 2'd3);

        // Reload clears flag and count.
        load(8'h40, 8'h11, 8'h22, 8'h33);
        check_regs("load3", 8'h40, 1'b0, 2'd0);

        // Hold while e=0; carries still track acc +/- op_b.
        for (int i = 0; i < 4; i++) begin
            drive(3'b001, 1'(i % 2), 1'b0);
            check($sformatf("hold%0d.c7", i), 32'(c7), (i % 2) ? 32'h1 : 32'h0);
            check($sformatf("hold%0d.c6", i), 32'(c6), (i % 2) ? 32'h1 : 32'h0);
            tick();
            check_regs($sformatf("hold%0d", i), 8'h40, 1'b0, 2'd0);
        end

        // Unused select with e=1 changes nothing.
        drive(3'b010, 1'b0, 1'b1);
        check("nop.c7", 32'(c7), 32'h0);
        tick();
        check_regs("nop", 8'h40, 1'b0, 2'd0);

        // Operand registers survived the hold.
        drive(3'b001, 1'b0, 1'b1); tick();
        check("opb.acc", 32'(acc), 32'h51);
        drive(3'b011, 1'b0, 1'b1); tick();
        check("opc.acc", 32'(acc), 32'h73);
        drive(3'b101, 1'b1, 1'b1); tick();
        check_regs("opd", 8'h40, 1'b0, 2'd3);

        // Negative overflow: 0x80 - 0x01.
        load(8'h80, 8'h01, 8'h00, 8'h00);
        drive(3'b001, 1'b1, 1'b1);
        check("novf.c6", 32'(c6), 32'h0);
        check("novf.c7", 32'(c7), 32'h1);
        tick();
`ifdef LCU_DATAPATH_SATURATE_EN
        check_regs("novf", 8'h80, 1'b1, 2'd1);
`else
        check_regs("novf", 8'h7F, 1'b1, 2'd1);
`endif

        // Reset beats a concurrent step.
        drive(3'b001, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        check_regs("rst_win", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        e = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
